// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//   Shares one single-ported unified memory between the instruction-fetch
//   port (IF) and the load/store port (DM). Each access is sequenced as
//   IDLE -> BUSY_x -> IDLE. The memory request and the port ready pulses
//   are registered. The per-port stall flags are combinational and feed
//   the pipeline hazard control.
//
//   Optional feature macro: ARB_RR_EN
//     undefined : fixed priority. DM wins a simultaneous request.
//     defined   : round-robin. A tie goes to the port not granted last.
//                 The first tie after reset goes to DM.
//
// Ports
//   i_clk, i_rst            clock; synchronous active-high reset
//   i_if_req, i_if_addr     fetch request and address (may be withdrawn)
//   o_if_ready, o_if_rdata  one-cycle fetch completion pulse and word
//   o_if_stall              i_if_req & ~o_if_ready
//   i_dm_req, i_dm_we,
//   i_dm_addr, i_dm_wdata   load/store request; held until o_dm_ready
//   o_dm_ready, o_dm_rdata  one-cycle completion pulse; load data
//   o_dm_stall              i_dm_req & ~o_dm_ready
//   o_mem_req, o_mem_we,
//   o_mem_addr, o_mem_wdata memory request with latched attributes
//   i_mem_rdata, i_mem_ready memory read data and completion strobe
module mem_port_arbiter #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_if_req,
    input  logic [ADDR_W-1:0] i_if_addr,
    output logic              o_if_ready,
    output logic [DATA_W-1:0] o_if_rdata,
    output logic              o_if_stall,
    input  logic              i_dm_req,
    input  logic              i_dm_we,
    input  logic [ADDR_W-1:0] i_dm_addr,
    input  logic [DATA_W-1:0] i_dm_wdata,
    output logic              o_dm_ready,
    output logic [DATA_W-1:0] o_dm_rdata,
    output logic              o_dm_stall,
    output logic              o_mem_req,
    output logic              o_mem_we,
    output logic [ADDR_W-1:0] o_mem_addr,
    output logic [DATA_W-1:0] o_mem_wdata,
    input  logic [DATA_W-1:0] i_mem_rdata,
    input  logic              i_mem_ready
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_BUSY_IF = 2'd1,
        S_BUSY_DM = 2'd2
    } state_t;

    state_t              r_state;
    logic                r_if_ready;
    logic                r_dm_ready;
    logic [DATA_W-1:0]   r_if_rdata;
    logic [DATA_W-1:0]   r_dm_rdata;
    logic                r_mem_req;
    logic                r_mem_we;
    logic [ADDR_W-1:0]   r_mem_addr;
    logic [DATA_W-1:0]   r_mem_wdata;

    logic                w_if_cand;
    logic                w_dm_cand;
    logic                w_grant_dm;
    logic                w_fetch_live;

    // A request seen in its own ready cycle belongs to the access that just
    // finished, so it is not eligible for a grant.
    assign w_if_cand = i_if_req & ~r_if_ready;
    assign w_dm_cand = i_dm_req & ~r_dm_ready;

`ifdef ARB_RR_EN
    // 1 = DM was granted last. The reset value is IF, so DM wins the first tie.
    logic r_last_dm;
    assign w_grant_dm = w_dm_cand & (~w_if_cand | ~r_last_dm);
`else
    assign w_grant_dm = w_dm_cand;
`endif

    // The fetch is still wanted only if the requester holds the same address.
    assign w_fetch_live = i_if_req & (i_if_addr == r_mem_addr);

    // Access sequencer: grant, wait for memory, then pulse the port ready.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state     <= S_IDLE;
            r_if_ready  <= 1'b0;
            r_dm_ready  <= 1'b0;
            r_if_rdata  <= '0;
            r_dm_rdata  <= '0;
            r_mem_req   <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
`ifdef ARB_RR_EN
            r_last_dm   <= 1'b0;
`endif
        end else begin
            r_if_ready <= 1'b0;
            r_dm_ready <= 1'b0;
            unique case (r_state)
                S_IDLE: begin
                    if (w_grant_dm) begin
                        r_state     <= S_BUSY_DM;
                        r_mem_req   <= 1'b1;
                        r_mem_we    <= i_dm_we;
                        r_mem_addr  <= i_dm_addr;
                        r_mem_wdata <= i_dm_wdata;
`ifdef ARB_RR_EN
                        r_last_dm   <= 1'b1;
`endif
                    end else if (w_if_cand) begin
                        r_state     <= S_BUSY_IF;
                        r_mem_req   <= 1'b1;
                        r_mem_we    <= 1'b0;
                        r_mem_addr  <= i_if_addr;
`ifdef ARB_RR_EN
                        r_last_dm   <= 1'b0;
`endif
                    end
                end
                S_BUSY_IF: begin
                    if (i_mem_ready) begin
                        r_state   <= S_IDLE;
                        r_mem_req <= 1'b0;
                        // A withdrawn or redirected fetch completes silently.
                        if (w_fetch_live) begin
                            r_if_ready <= 1'b1;
                            r_if_rdata <= i_mem_rdata;
                        end
                    end
                end
                S_BUSY_DM: begin
                    if (i_mem_ready) begin
                        r_state    <= S_IDLE;
                        r_mem_req  <= 1'b0;
                        r_dm_ready <= 1'b1;
                        if (!r_mem_we) begin
                            r_dm_rdata <= i_mem_rdata;
                        end
                    end
                end
                default: begin
                    r_state   <= S_IDLE;
                    r_mem_req <= 1'b0;
                end
            endcase
        end
    end

    assign o_if_ready  = r_if_ready;
    assign o_if_rdata  = r_if_rdata;
    assign o_dm_ready  = r_dm_ready;
    assign o_dm_rdata  = r_dm_rdata;
    assign o_mem_req   = r_mem_req;
    assign o_mem_we    = r_mem_we;
    assign o_mem_addr  = r_mem_addr;
    assign o_mem_wdata = r_mem_wdata;
    assign o_if_stall  = i_if_req & ~r_if_ready;
    assign o_dm_stall  = i_dm_req & ~r_dm_ready;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Testbench for mem_port_arbiter.
// The bench runs a series of directed timing scenarios, then random traffic
// on both ports against a behavioural memory. Expected read data is queued
// when each request is issued. A negedge monitor pops and compares the
// queued value on every ready pulse.
module tb_mem_port_arbiter;

    localparam int unsigned AW = 32;
    localparam int unsigned DW = 32;
`ifdef ARB_RR_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          i_rst;
    logic          i_if_req;
    logic [AW-1:0] i_if_addr;
    logic          o_if_ready;
    logic [DW-1:0] o_if_rdata;
    logic          o_if_stall;
    logic          i_dm_req;
    logic          i_dm_we;
    logic [AW-1:0] i_dm_addr;
    logic [DW-1:0] i_dm_wdata;
    logic          o_dm_ready;
    logic [DW-1:0] o_dm_rdata;
    logic          o_dm_stall;
    logic          o_mem_req;
    logic          o_mem_we;
    logic [AW-1:0] o_mem_addr;
    logic [DW-1:0] o_mem_wdata;
    logic [DW-1:0] i_mem_rdata;
    logic          i_mem_ready;

    always #5 clk = ~clk;

    mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .i_clk(clk), .i_rst(i_rst),
        .i_if_req(i_if_req), .i_if_addr(i_if_addr),
        .o_if_ready(o_if_ready), .o_if_rdata(o_if_rdata), .o_if_stall(o_if_stall),
        .i_dm_req(i_dm_req), .i_dm_we(i_dm_we), .i_dm_addr(i_dm_addr),
        .i_dm_wdata(i_dm_wdata), .o_dm_ready(o_dm_ready), .o_dm_rdata(o_dm_rdata),
        .o_dm_stall(o_dm_stall), .o_mem_req(o_mem_req), .o_mem_we(o_mem_we),
        .o_mem_addr(o_mem_addr), .o_mem_wdata(o_mem_wdata),
        .i_mem_rdata(i_mem_rdata), .i_mem_ready(i_mem_ready)
    );

    int n_cmp = 0;
    int n_err = 0;

    // mem: contents of the memory model. shadow: the reference view, updated when a store is issued.
    logic [DW-1:0] mem    [logic [AW-1:0]];
    logic [DW-1:0] shadow [logic [AW-1:0]];
    logic [DW-1:0] if_q[$];
    logic [DW-1:0] dm_q[$];
    logic [DW-1:0] last_load = '0;
    int            wait_cfg  = 0;
    bit            rand_wait = 1'b0;
    bit            rnd_go    = 1'b0;

    task automatic chk_b(string name, logic act, logic exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: actual=%b required=%b (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic chk_w(string name, logic [31:0] act, logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: actual=%h required=%h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic miss(string name, logic [31:0] act);
        n_cmp++;
        n_err++;
        $display("FAIL %s: actual ready with data %h, required no ready (t=%0t)", name, act, $time);
    endtask

    function automatic logic [DW-1:0] init_word(logic [AW-1:0] a);
        return (a * 32'h9E37_79B1) ^ 32'hC0DE_0000;
    endfunction

    function automatic logic [DW-1:0] rd_mem(logic [AW-1:0] a);
        return mem.exists(a) ? mem[a] : init_word(a);
    endfunction

    function automatic logic [DW-1:0] rd_shadow(logic [AW-1:0] a);
        return shadow.exists(a) ? shadow[a] : init_word(a);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue_if(logic [AW-1:0] a);
        i_if_req  = 1'b1;
        i_if_addr = a;
        if_q.push_back(rd_shadow(a));
    endtask

    task automatic issue_dm(logic we, logic [AW-1:0] a, logic [DW-1:0] d);
        i_dm_req   = 1'b1;
        i_dm_we    = we;
        i_dm_addr  = a;
        i_dm_wdata = d;
        if (we) begin
            shadow[a] = d;
        end else begin
            last_load = rd_shadow(a);
        end
        // The load data register holds its last load value across a store.
        dm_q.push_back(last_load);
    endtask

    // Drop each request after its ready pulse. The wait is bounded.
    task automatic drain(string name, int budget);
        int n = 0;
        while ((i_if_req || i_dm_req) && n < budget) begin
            tick();
            n++;
            if (o_if_ready) i_if_req = 1'b0;
            if (o_dm_ready) i_dm_req = 1'b0;
        end
        chk_b(name, i_if_req | i_dm_req, 1'b0);
    endtask

    // Behavioural memory: a fixed or random number of wait states per access.
    initial begin : mem_model
        int            cnt  = 0;
        bit            busy = 1'b0;
        logic [AW-1:0] a0   = '0;
        logic          w0   = 1'b0;
        logic [DW-1:0] d0   = '0;
        i_mem_ready = 1'b0;
        i_mem_rdata = '0;
        forever begin
            tick();
            i_mem_ready = 1'b0;
            i_mem_rdata = $urandom();
            if (!o_mem_req) begin
                busy = 1'b0;
            end else begin
                if (!busy) begin
                    busy = 1'b1;
                    cnt  = rand_wait ? int'($urandom_range(0, 3)) : wait_cfg;
                    a0 = o_mem_addr; w0 = o_mem_we; d0 = o_mem_wdata;
                end else begin
                    chk_w("mem_addr_stable", o_mem_addr, a0);
                    chk_b("mem_we_stable", o_mem_we, w0);
                    if (w0) chk_w("mem_wdata_stable", o_mem_wdata, d0);
                end
                if (cnt == 0) begin
                    i_mem_ready = 1'b1;
                    busy        = 1'b0;
                    if (o_mem_we) mem[o_mem_addr] = o_mem_wdata;
                    else          i_mem_rdata     = rd_mem(o_mem_addr);
                end else begin
                    cnt--;
                end
            end
        end
    end

    // Monitor: stall flags every cycle; pop and compare on each ready pulse.
    always @(negedge clk) begin
        chk_b("if_stall", o_if_stall, i_if_req & ~o_if_ready);
        chk_b("dm_stall", o_dm_stall, i_dm_req & ~o_dm_ready);
        if (o_if_ready) begin
            if (if_q.size() == 0) miss("if_ready_unexpected", o_if_rdata);
            else                  chk_w("if_rdata", o_if_rdata, if_q.pop_front());
        end
        if (o_dm_ready) begin
            if (dm_q.size() == 0) miss("dm_ready_unexpected", o_dm_rdata);
            else                  chk_w("dm_rdata", o_dm_rdata, dm_q.pop_front());
        end
    end

    // Random fetch requester; it sometimes redirects or withdraws an in-flight fetch.
    initial begin : if_gen
        bit            busy = 1'b0;
        logic [AW-1:0] a;
        wait (rnd_go);
        while (rnd_go || busy) begin
            tick();
            if (o_if_ready) busy = 1'b0;
            if (busy && $urandom_range(0, 9) == 0) begin
                if_q.delete();
                if (!rnd_go || $urandom_range(0, 2) == 0) begin
                    busy = 1'b0;
                end else begin
                    do a = AW'(4 * $urandom_range(0, 63)); while (a == i_if_addr);
                    issue_if(a);
                end
            end else if (!busy && rnd_go && $urandom_range(0, 1) == 1) begin
                busy = 1'b1;
                issue_if(AW'(4 * $urandom_range(0, 63)));
            end
            i_if_req = busy;
        end
        i_if_req = 1'b0;
    end

    // Random load/store requester confined to a 16-word data region.
    initial begin : dm_gen
        bit busy = 1'b0;
        wait (rnd_go);
        while (rnd_go || busy) begin
            tick();
            if (o_dm_ready) busy = 1'b0;
            if (!busy && rnd_go && $urandom_range(0, 2) == 0) begin
                busy = 1'b1;
                issue_dm(1'($urandom_range(0, 1)), 32'h1000 + AW'(4 * $urandom_range(0, 15)),
                         $urandom());
            end
            i_dm_req = busy;
        end
        i_dm_req = 1'b0;
    end

    initial begin : main
        logic [DW-1:0] held;
        int            n;

        // Reset held two cycles with both requests high.
        i_rst = 1'b1; i_if_req = 1'b1; i_dm_req = 1'b1;
        i_if_addr = '0; i_dm_we = 1'b0; i_dm_addr = '0; i_dm_wdata = '0;
        tick(); tick();
        chk_b("t1_mem_req", o_mem_req, 1'b0);
        chk_b("t1_if_ready", o_if_ready, 1'b0);
        chk_b("t1_dm_ready", o_dm_ready, 1'b0);
        chk_b("t1_if_stall", o_if_stall, 1'b1);
        chk_b("t1_dm_stall", o_dm_stall, 1'b1);
        chk_w("t1_if_rdata", o_if_rdata, '0);
        chk_w("t1_dm_rdata", o_dm_rdata, '0);
        i_rst = 1'b0; i_if_req = 1'b0; i_dm_req = 1'b0;
        tick(); tick();

        // Lone fetch with a zero-wait memory. if_ready is expected in cycle 2.
        wait_cfg = 0;
        mem[32'h10] = 32'hDEAD; shadow[32'h10] = 32'hDEAD;
        issue_if(32'h10);
        tick();
        chk_b("t2_c1_mem_req", o_mem_req, 1'b1);
        chk_w("t2_c1_mem_addr", o_mem_addr, 32'h10);
        chk_b("t2_c1_mem_we", o_mem_we, 1'b0);
        chk_b("t2_c1_if_ready", o_if_ready, 1'b0);
        tick();
        chk_b("t2_c2_if_ready", o_if_ready, 1'b1);
        chk_w("t2_c2_if_rdata", o_if_rdata, 32'hDEAD);
        i_if_req = 1'b0;
        tick();
        chk_b("t2_c3_if_ready_pulse", o_if_ready, 1'b0);
        tick();

        // Collision: DM wins, completes after 2 wait states. IF is granted in the DM ready cycle.
        wait_cfg = 2;
        issue_if(32'h30);
        issue_dm(1'b0, 32'h80, '0);
        tick();
        chk_w("t3_c1_mem_addr", o_mem_addr, 32'h80);
        chk_b("t3_c1_mem_we", o_mem_we, 1'b0);
        tick(); tick();
        chk_b("t3_c3_dm_ready", o_dm_ready, 1'b0);
        wait_cfg = 0;
        tick();
        chk_b("t3_c4_dm_ready", o_dm_ready, 1'b1);
        chk_b("t3_c4_mem_req", o_mem_req, 1'b0);
        tick();
        i_dm_req = 1'b0;
        chk_b("t3_c5_mem_req", o_mem_req, 1'b1);
        chk_w("t3_c5_mem_addr", o_mem_addr, 32'h30);
        chk_b("t3_c5_dm_ready", o_dm_ready, 1'b0);
        tick();
        chk_b("t3_c6_if_ready", o_if_ready, 1'b1);
        i_if_req = 1'b0;
        tick();
        chk_b("t3_c7_mem_req", o_mem_req, 1'b0);
        tick();

        // Tie right after a DM grant: round-robin picks IF, fixed priority picks DM.
        issue_dm(1'b0, 32'h84, '0);
        tick();
        chk_w("t3b_lone_dm_addr", o_mem_addr, 32'h84);
        tick();
        chk_b("t3b_lone_dm_ready", o_dm_ready, 1'b1);
        i_dm_req = 1'b0;
        tick();
        issue_if(32'h50);
        issue_dm(1'b0, 32'h88, '0);
        tick();
        chk_w("t3b_tie_winner", o_mem_addr, RR ? 32'h50 : 32'h88);
        drain("t3b_drain", 40);
        tick();

        // Flush: the fetch of 0x20 is redirected to 0x40 before memory completes.
        wait_cfg = 3;
        issue_if(32'h20);
        tick();
        chk_w("t4_c1_mem_addr", o_mem_addr, 32'h20);
        tick();
        if_q.delete();
        issue_if(32'h40);
        wait_cfg = 0;
        for (int c = 3; c <= 5; c++) begin
            tick();
            chk_b("t4_no_if_ready", o_if_ready, 1'b0);
        end
        tick();
        chk_b("t4_c6_mem_req", o_mem_req, 1'b1);
        chk_w("t4_c6_mem_addr", o_mem_addr, 32'h40);
        tick();
        chk_b("t4_c7_if_ready", o_if_ready, 1'b1);
        chk_w("t4_c7_if_rdata", o_if_rdata, rd_shadow(32'h40));
        i_if_req = 1'b0;
        tick();

        // Store: exact attributes on the memory side; dm_rdata keeps the previous load.
        wait_cfg = 1;
        held = last_load;
        issue_dm(1'b1, 32'h100, 32'h55);
        tick();
        chk_b("t5_mem_we", o_mem_we, 1'b1);
        chk_w("t5_mem_addr", o_mem_addr, 32'h100);
        chk_w("t5_mem_wdata", o_mem_wdata, 32'h55);
        tick();
        chk_b("t5_c2_dm_ready", o_dm_ready, 1'b0);
        tick();
        chk_b("t5_c3_dm_ready", o_dm_ready, 1'b1);
        chk_w("t5_dm_rdata_held", o_dm_rdata, held);
        i_dm_req = 1'b0;
        chk_w("t5_mem_written", rd_mem(32'h100), 32'h55);
        tick();

        // Reset while BUSY_DM with the memory still waiting.
        wait_cfg = 5;
        issue_dm(1'b0, 32'h104, '0);
        tick();
        chk_b("t6_c1_mem_req", o_mem_req, 1'b1);
        i_rst = 1'b1;
        tick();
        dm_q.delete();
        last_load = '0;
        chk_b("t6_mem_req_after_rst", o_mem_req, 1'b0);
        chk_b("t6_dm_ready_after_rst", o_dm_ready, 1'b0);
        chk_w("t6_dm_rdata_after_rst", o_dm_rdata, '0);
        i_rst = 1'b0;
        i_dm_req = 1'b0;
        for (int c = 0; c < 4; c++) begin
            tick();
            chk_b("t6_idle_mem_req", o_mem_req, 1'b0);
        end

        // Random traffic on both ports with random memory latency.
        rand_wait = 1'b1;
        rnd_go    = 1'b1;
        repeat (3000) tick();
        rnd_go = 1'b0;
        n = 0;
        while ((if_q.size() != 0 || dm_q.size() != 0 || i_if_req || i_dm_req) && n < 300) begin
            tick();
            n++;
        end
        chk_w("drain_if_q", 32'(if_q.size()), 32'd0);
        chk_w("drain_dm_q", 32'(dm_q.size()), 32'd0);
        chk_b("drain_reqs", i_if_req | i_dm_req, 1'b0);
        tick(); tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
